// File: rtl/mips_ctrl_pipe.sv
// Control/specifier pipeline (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core,
// with load-use stall, taken-branch flush and ALU operand forwarding selects.
module mips_ctrl_pipe (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_alusrc,
   input  logic       id_regdst,
   input  logic       id_branch,
   input  logic       id_memwrite,
   input  logic       id_memread,
   input  logic       id_memtoreg,
   input  logic       id_regwrite,
   input  logic [1:0] id_aluop,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       ex_zero,
   output logic       ex_alusrc,
   output logic       ex_regdst,
   output logic [1:0] ex_aluop,
   output logic [4:0] ex_rs,
   output logic [4:0] ex_rt,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       mem_branch,
   output logic       mem_memwrite,
   output logic       mem_memread,
   output logic [4:0] mem_dst,
   output logic       pc_src,
   output logic       wb_memtoreg,
   output logic       wb_regwrite,
   output logic [4:0] wb_dst,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush
);

   logic       ex_alusrc_r, ex_regdst_r, ex_branch_r, ex_memwrite_r;
   logic       ex_memread_r, ex_memtoreg_r, ex_regwrite_r;
   logic [1:0] ex_aluop_r;
   logic [4:0] ex_rs_r, ex_rt_r, ex_rd_r;

   logic       mem_branch_r, mem_memwrite_r, mem_memread_r;
   logic       mem_memtoreg_r, mem_regwrite_r, mem_zero_r;
   logic [4:0] mem_dst_r;

   logic       wb_memtoreg_r, wb_regwrite_r;
   logic [4:0] wb_dst_r;

   logic       stall_s, flush_s, idex_bubble_s;
   logic [4:0] ex_dst_s;

   // A newer producer (EX/MEM) always shadows an older one (MEM/WB); $0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       m_rw,
                                          input logic [4:0] m_dst,
                                          input logic       w_rw,
                                          input logic [4:0] w_dst);
      logic [1:0] sel;
      if (m_rw && (m_dst != 5'd0) && (m_dst == src)) begin
         sel = 2'b10;
      end else if (w_rw && (w_dst != 5'd0) && (w_dst == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and EX destination select.
   always_comb begin
      flush_s = mem_branch_r & mem_zero_r;
      if (ex_memread_r && (ex_rt_r != 5'd0) && ((ex_rt_r == id_rs) || (ex_rt_r == id_rt))) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
      idex_bubble_s = stall_s | flush_s;
      if (ex_regdst_r) begin
         ex_dst_s = ex_rd_r;
      end else begin
         ex_dst_s = ex_rt_r;
      end
   end

   // ID/EX register: specifiers always advance, control is zeroed on stall or flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_alusrc_r   <= 1'b0;
         ex_regdst_r   <= 1'b0;
         ex_branch_r   <= 1'b0;
         ex_memwrite_r <= 1'b0;
         ex_memread_r  <= 1'b0;
         ex_memtoreg_r <= 1'b0;
         ex_regwrite_r <= 1'b0;
         ex_aluop_r    <= 2'b00;
         ex_rs_r       <= 5'd0;
         ex_rt_r       <= 5'd0;
         ex_rd_r       <= 5'd0;
      end else begin
         ex_rs_r <= id_rs;
         ex_rt_r <= id_rt;
         ex_rd_r <= id_rd;
         if (idex_bubble_s) begin
            ex_alusrc_r   <= 1'b0;
            ex_regdst_r   <= 1'b0;
            ex_branch_r   <= 1'b0;
            ex_memwrite_r <= 1'b0;
            ex_memread_r  <= 1'b0;
            ex_memtoreg_r <= 1'b0;
            ex_regwrite_r <= 1'b0;
            ex_aluop_r    <= 2'b00;
         end else begin
            ex_alusrc_r   <= id_alusrc;
            ex_regdst_r   <= id_regdst;
            ex_branch_r   <= id_branch;
            ex_memwrite_r <= id_memwrite;
            ex_memread_r  <= id_memread;
            ex_memtoreg_r <= id_memtoreg;
            ex_regwrite_r <= id_regwrite;
            ex_aluop_r    <= id_aluop;
         end
      end
   end

   // EX/MEM register: a taken branch squashes the instruction currently in EX.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_branch_r   <= 1'b0;
         mem_memwrite_r <= 1'b0;
         mem_memread_r  <= 1'b0;
         mem_memtoreg_r <= 1'b0;
         mem_regwrite_r <= 1'b0;
         mem_zero_r     <= 1'b0;
         mem_dst_r      <= 5'd0;
      end else begin
         mem_dst_r  <= ex_dst_s;
         mem_zero_r <= ex_zero;
         if (flush_s) begin
            mem_branch_r   <= 1'b0;
            mem_memwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            mem_memtoreg_r <= 1'b0;
            mem_regwrite_r <= 1'b0;
         end else begin
            mem_branch_r   <= ex_branch_r;
            mem_memwrite_r <= ex_memwrite_r;
            mem_memread_r  <= ex_memread_r;
            mem_memtoreg_r <= ex_memtoreg_r;
            mem_regwrite_r <= ex_regwrite_r;
         end
      end
   end

   // MEM/WB register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_memtoreg_r <= 1'b0;
         wb_regwrite_r <= 1'b0;
         wb_dst_r      <= 5'd0;
      end else begin
         wb_memtoreg_r <= mem_memtoreg_r;
         wb_regwrite_r <= mem_regwrite_r;
         wb_dst_r      <= mem_dst_r;
      end
   end

   assign ex_alusrc    = ex_alusrc_r;
   assign ex_regdst    = ex_regdst_r;
   assign ex_aluop     = ex_aluop_r;
   assign ex_rs        = ex_rs_r;
   assign ex_rt        = ex_rt_r;
   assign mem_branch   = mem_branch_r;
   assign mem_memwrite = mem_memwrite_r;
   assign mem_memread  = mem_memread_r;
   assign mem_dst      = mem_dst_r;
   assign wb_memtoreg  = wb_memtoreg_r;
   assign wb_regwrite  = wb_regwrite_r;
   assign wb_dst       = wb_dst_r;

   assign fwd_a      = fwd_sel(ex_rs_r, mem_regwrite_r, mem_dst_r, wb_regwrite_r, wb_dst_r);
   assign fwd_b      = fwd_sel(ex_rt_r, mem_regwrite_r, mem_dst_r, wb_regwrite_r, wb_dst_r);
   assign pc_src     = flush_s;
   assign ifid_flush = flush_s;
   assign pc_write   = ~stall_s | flush_s;
   assign ifid_write = ~stall_s | flush_s;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// Scoreboard bench for mips_ctrl_pipe: a stage-record reference model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_mips_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_alusrc, id_regdst, id_branch, id_memwrite, id_memread, id_memtoreg, id_regwrite;
   logic [1:0] id_aluop;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_zero;
   logic       ex_alusrc, ex_regdst;
   logic [1:0] ex_aluop;
   logic [4:0] ex_rs, ex_rt;
   logic [1:0] fwd_a, fwd_b;
   logic       mem_branch, mem_memwrite, mem_memread;
   logic [4:0] mem_dst;
   logic       pc_src, wb_memtoreg, wb_regwrite;
   logic [4:0] wb_dst;
   logic       pc_write, ifid_write, ifid_flush;

   always #5 clk = ~clk;

   mips_ctrl_pipe dut (
      .clk(clk), .reset(reset),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_branch(id_branch),
      .id_memwrite(id_memwrite), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
      .id_regwrite(id_regwrite), .id_aluop(id_aluop),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
      .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .mem_branch(mem_branch), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_dst(mem_dst), .pc_src(pc_src), .wb_memtoreg(wb_memtoreg),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush)
   );

   typedef struct packed {
      logic alusrc, regdst, branch, memwrite, memread, memtoreg, regwrite;
      logic [1:0] aluop;
      logic [4:0] rs, rt, rd;
   } instr_t;

   typedef struct packed {
      logic branch, memwrite, memread, memtoreg, regwrite, zero;
      logic [4:0] dst;
   } memst_t;

   typedef struct packed {
      logic memtoreg, regwrite;
      logic [4:0] dst;
   } wbst_t;

   typedef struct packed {
      logic ex_alusrc, ex_regdst;
      logic [1:0] ex_aluop;
      logic [4:0] ex_rs, ex_rt;
      logic [1:0] fwd_a, fwd_b;
      logic mem_branch, mem_memwrite, mem_memread;
      logic [4:0] mem_dst;
      logic pc_src, wb_memtoreg, wb_regwrite;
      logic [4:0] wb_dst;
      logic pc_write, ifid_write, ifid_flush;
   } exp_t;

   localparam int K_NOP = 0, K_RTYPE = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_RAND = 5;

   exp_t   exp_q[$];
   exp_t   mon_e;
   instr_t m_ex;
   memst_t m_mem;
   wbst_t  m_wb;
   logic   m_valid = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic instr_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd);
      instr_t i;
      i = '0;
      i.rs = rs; i.rt = rt; i.rd = rd;
      case (kind)
         K_RTYPE: begin i.regdst = 1'b1; i.regwrite = 1'b1; i.aluop = 2'b10; end
         K_LW:    begin i.alusrc = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1; end
         K_SW:    begin i.alusrc = 1'b1; i.memwrite = 1'b1; end
         K_BEQ:   begin i.branch = 1'b1; i.aluop = 2'b01; end
         K_RAND: begin
            i.alusrc = 1'($urandom); i.regdst = 1'($urandom); i.branch = 1'($urandom);
            i.memwrite = 1'($urandom); i.memread = 1'($urandom);
            i.memtoreg = 1'($urandom); i.regwrite = 1'($urandom); i.aluop = 2'($urandom);
         end
         default: ;
      endcase
      return i;
   endfunction

   function automatic instr_t rand_instr();
      return mk(int'($urandom_range(0, 5)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
   endfunction

   // Reference forwarding: youngest in-flight writer of a nonzero register wins.
   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (src == 5'd0) return 2'b00;
      if (m_mem.regwrite && m_mem.dst == src) return 2'b10;
      if (m_wb.regwrite && m_wb.dst == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic step(input instr_t ins, input logic z, input logic rst);
      exp_t   e;
      instr_t bubble;
      logic   stall, taken;
      @(posedge clk);
      #1;
      reset = rst; ex_zero = z;
      id_alusrc = ins.alusrc; id_regdst = ins.regdst; id_branch = ins.branch;
      id_memwrite = ins.memwrite; id_memread = ins.memread; id_memtoreg = ins.memtoreg;
      id_regwrite = ins.regwrite; id_aluop = ins.aluop;
      id_rs = ins.rs; id_rt = ins.rt; id_rd = ins.rd;
      stall = m_ex.memread && (m_ex.rt != 5'd0) && (m_ex.rt == ins.rs || m_ex.rt == ins.rt);
      taken = m_mem.branch && m_mem.zero;
      if (m_valid) begin
         e.ex_alusrc = m_ex.alusrc; e.ex_regdst = m_ex.regdst; e.ex_aluop = m_ex.aluop;
         e.ex_rs = m_ex.rs; e.ex_rt = m_ex.rt;
         e.fwd_a = ref_fwd(m_ex.rs); e.fwd_b = ref_fwd(m_ex.rt);
         e.mem_branch = m_mem.branch; e.mem_memwrite = m_mem.memwrite;
         e.mem_memread = m_mem.memread; e.mem_dst = m_mem.dst;
         e.pc_src = taken;
         e.wb_memtoreg = m_wb.memtoreg; e.wb_regwrite = m_wb.regwrite; e.wb_dst = m_wb.dst;
         e.pc_write = taken || !stall;
         e.ifid_write = taken || !stall;
         e.ifid_flush = taken;
         exp_q.push_back(e);
      end
      if (rst) begin
         m_ex = '0; m_mem = '0; m_wb = '0; m_valid = 1'b1;
      end else begin
         m_wb = '{memtoreg: m_mem.memtoreg, regwrite: m_mem.regwrite, dst: m_mem.dst};
         m_mem.dst = m_ex.regdst ? m_ex.rd : m_ex.rt;
         m_mem.zero = z;
         m_mem.branch = taken ? 1'b0 : m_ex.branch;
         m_mem.memwrite = taken ? 1'b0 : m_ex.memwrite;
         m_mem.memread = taken ? 1'b0 : m_ex.memread;
         m_mem.memtoreg = taken ? 1'b0 : m_ex.memtoreg;
         m_mem.regwrite = taken ? 1'b0 : m_ex.regwrite;
         bubble = '0;
         bubble.rs = ins.rs; bubble.rt = ins.rt; bubble.rd = ins.rd;
         m_ex = (stall || taken) ? bubble : ins;
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("ex_alusrc", 32'(ex_alusrc), 32'(mon_e.ex_alusrc));
         chk("ex_regdst", 32'(ex_regdst), 32'(mon_e.ex_regdst));
         chk("ex_aluop", 32'(ex_aluop), 32'(mon_e.ex_aluop));
         chk("ex_rs", 32'(ex_rs), 32'(mon_e.ex_rs));
         chk("ex_rt", 32'(ex_rt), 32'(mon_e.ex_rt));
         chk("fwd_a", 32'(fwd_a), 32'(mon_e.fwd_a));
         chk("fwd_b", 32'(fwd_b), 32'(mon_e.fwd_b));
         chk("mem_branch", 32'(mem_branch), 32'(mon_e.mem_branch));
         chk("mem_memwrite", 32'(mem_memwrite), 32'(mon_e.mem_memwrite));
         chk("mem_memread", 32'(mem_memread), 32'(mon_e.mem_memread));
         chk("mem_dst", 32'(mem_dst), 32'(mon_e.mem_dst));
         chk("pc_src", 32'(pc_src), 32'(mon_e.pc_src));
         chk("wb_memtoreg", 32'(wb_memtoreg), 32'(mon_e.wb_memtoreg));
         chk("wb_regwrite", 32'(wb_regwrite), 32'(mon_e.wb_regwrite));
         chk("wb_dst", 32'(wb_dst), 32'(mon_e.wb_dst));
         chk("pc_write", 32'(pc_write), 32'(mon_e.pc_write));
         chk("ifid_write", 32'(ifid_write), 32'(mon_e.ifid_write));
         chk("ifid_flush", 32'(ifid_flush), 32'(mon_e.ifid_flush));
      end
   end

   initial begin
      reset = 1'b1; ex_zero = 1'b0;
      id_alusrc = 1'b0; id_regdst = 1'b0; id_branch = 1'b0; id_memwrite = 1'b0;
      id_memread = 1'b0; id_memtoreg = 1'b0; id_regwrite = 1'b0; id_aluop = 2'b00;
      id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
      m_ex = '0; m_mem = '0; m_wb = '0;
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b1);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // Load-use: lw $2 then a consumer of $2 (re-presented while held).
      step(mk(K_LW, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd2, 5'd3, 5'd4), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd2, 5'd3, 5'd4), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // $0 guards on stall and forwarding.
      step(mk(K_LW, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd0, 5'd0, 5'd6), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // Forward priority, then MEM/WB-only forwarding.
      step(mk(K_RTYPE, 5'd1, 5'd1, 5'd5), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd1, 5'd5), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd5, 5'd5, 5'd7), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd1, 5'd5), 1'b0, 1'b0);
      step(mk(K_SW, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd5, 5'd5, 5'd7), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // Taken beq followed by three younger instructions.
      step(mk(K_BEQ, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd2, 5'd4), 1'b1, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd2, 5'd5), 1'b1, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // Stall and flush in the same cycle.
      step(mk(K_BEQ, 5'd1, 5'd1, 5'd0), 1'b1, 1'b0);
      step(mk(K_LW, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0);
      step(mk(K_RTYPE, 5'd2, 5'd3, 5'd4), 1'b1, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      // Reset with R-types in every stage.
      step(mk(K_RTYPE, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd2, 5'd3, 5'd1), 1'b0, 1'b0);
      step(mk(K_RTYPE, 5'd1, 5'd3, 5'd3), 1'b0, 1'b1);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      for (int n = 0; n < 400; n++) begin
         step(rand_instr(), 1'($urandom), ($urandom_range(0, 59) == 0));
      end
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      step(mk(K_NOP, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Carries decoded control bits and register specifiers from the decode stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core. It sits directly downstream of the main opcode decoder. It also generates load-use stalls, branch flushes and ALU operand forwarding selects. Datapath values (operands, ALU result, memory data) are outside this block; only control and register numbers pass through it.

## Interface
Parameters:
- none (register specifier width fixed at 5, ALUOp width fixed at 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all pipeline registers
- id_alusrc, id_regdst, id_branch, id_memwrite, id_memread, id_memtoreg, id_regwrite  in  1 each  decoder outputs for the instruction currently in ID
- id_aluop  in  2  decoder ALUOp
- id_rs, id_rt, id_rd  in  5 each  specifier fields of the ID instruction
- ex_zero  in  1  ALU zero flag of the EX instruction
- ex_alusrc, ex_regdst  out  1  ID/EX register outputs
- ex_aluop  out  2  ID/EX register output
- ex_rs, ex_rt  out  5  ID/EX register outputs
- fwd_a, fwd_b  out  2  ALU operand A/B select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- mem_branch, mem_memwrite, mem_memread  out  1  EX/MEM register outputs
- mem_dst  out  5  EX/MEM destination register
- pc_src  out  1  branch taken; equals mem_branch & mem_zero
- wb_memtoreg, wb_regwrite  out  1  MEM/WB register outputs
- wb_dst  out  5  MEM/WB destination register
- pc_write, ifid_write  out  1  0 = hold PC / IF-ID register (stall)
- ifid_flush  out  1  1 = load a bubble (nop) into IF/ID

## Operation
- ID/EX captures all nine id_* control bits plus id_rs, id_rt, id_rd each cycle.
- EX dst = ex_regdst ? ex_rd : ex_rt. EX/MEM captures branch, memwrite, memread, memtoreg, regwrite, dst, and ex_zero as mem_zero.
- MEM/WB captures memtoreg, regwrite, dst.
- Load-use hazard (`stall`) = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - On stall: pc_write = 0, ifid_write = 0, and ID/EX control bits load 0 (bubble). Specifiers still load.
- Branch flush (`flush`) = pc_src.
  - On flush: ifid_flush = 1, ID/EX and EX/MEM control bits load 0. MEM/WB loads normally.
  - Flush has priority over stall: when both are true, pc_write = 1, ifid_write = 1, flush actions apply.
- Forwarding for A (B identical, using ex_rt):
  - 10 if mem_regwrite & mem_dst != 0 & mem_dst == ex_rs;
  - else 01 if wb_regwrite & wb_dst != 0 & wb_dst == ex_rs;
  - else 00.
  - EX/MEM wins over MEM/WB.
- Bubbles have regwrite = 0, memwrite = 0, memread = 0, branch = 0, so they never trigger hazards, forwarding or pc_src.

## Timing
- All pipeline registers update on rising clk. Stage outputs are registered; ID inputs reach ex_* outputs one cycle later, mem_* two, wb_* three.
- stall, flush, pc_src, fwd_a, fwd_b, pc_write, ifid_write and ifid_flush are combinational from current register state and id_* inputs, with no added latency.
- Reset (synchronous): every registered output is 0 after the first clk edge with reset high. This holds even when reset is raised mid-stream, and discards in-flight instructions.
- After reset: pc_write = 1, ifid_write = 1, ifid_flush = 0, fwd_a = fwd_b = 00.
- A load-use stall lasts exactly one cycle. Next cycle ex_memread = 0 (bubble), so the stall clears.
- A taken beq squashes exactly the 3 younger instructions: IF via ifid_flush, ID and EX via zeroed control.

## Test plan
- Load-use: lw $2 in EX (ex_memread=1, ex_rt=2), ID has id_rs=2 -> pc_write=0, ifid_write=0 for one cycle; next cycle ex_regwrite=0, ex_memread=0; following cycle pc_write=1.
- $0 guard: ex_memread=1, ex_rt=0, id_rs=0 -> no stall. mem_regwrite=1, mem_dst=0, ex_rs=0 -> fwd_a=00.
- Forward priority: mem_dst=5 and wb_dst=5, both regwrite=1, ex_rs=5, ex_rt=5 -> fwd_a=10, fwd_b=10. Drop mem_regwrite -> both 01.
- Branch taken: beq with ex_zero=1 reaches MEM -> pc_src=1, ifid_flush=1. Next cycle ex_* control and mem_* control are 0, and wb_* carry the beq (regwrite=0).
- Stall + flush same cycle: load-use condition true while pc_src=1 -> pc_write=1, ifid_flush=1, ID/EX control zeroed.
- Reset mid-stream: R-type instructions in all stages, reset high one cycle -> all ex_/mem_/wb_ outputs 0, pc_src=0, fwd_a=fwd_b=00.
